// File: rtl/bcd_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_seq_if
//  Description : Command/status bundle between the front end (master) and
//                the BCD sequencing controller (slave). The dir signal only
//                exists when BCD_DOWN_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface bcd_seq_if #(
    parameter int DIGITS = 2
);
    // Commands from the front end
    logic                  start;
    logic                  stop;
    logic                  clr;
    logic                  tick;
    logic [4*DIGITS-1:0]   limit;
`ifdef BCD_DOWN_EN
    logic                  dir;
`endif
    // Status back to the display datapath
    logic [4*DIGITS-1:0]   count;
    logic [DIGITS-1:0]     digit_en;
    logic [1:0]            state;
    logic                  busy;
    logic                  done;
    logic                  err;

`ifdef BCD_DOWN_EN
    modport master (output start, stop, clr, tick, limit, dir,
                    input  count, digit_en, state, busy, done, err);
    modport slave  (input  start, stop, clr, tick, limit, dir,
                    output count, digit_en, state, busy, done, err);
`else
    modport master (output start, stop, clr, tick, limit,
                    input  count, digit_en, state, busy, done, err);
    modport slave  (input  start, stop, clr, tick, limit,
                    output count, digit_en, state, busy, done, err);
`endif
endinterface
`default_nettype wire

// File: rtl/bcd_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_seq_ctrl
//  Description : Sequencing controller for a chain of BCD digit counters.
//                Steps a packed BCD count from its start value to a captured
//                terminal value under start/stop/clr/tick commands, with
//                per-digit change strobes and done/err pulses.
//                Optional feature macro: BCD_DOWN_EN (adds dir / down count).
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_seq_ctrl #(
    parameter int DIGITS = 2
) (
    input  wire logic  clk,
    input  wire logic  rst,
    bcd_seq_if.slave   bus
);

    localparam int c_w = 4 * DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    state_t              r_state;
    logic [c_w-1:0]      r_count;
    logic [c_w-1:0]      r_limit;
    logic [DIGITS-1:0]   r_digit_en;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    logic [c_w-1:0]      w_up;
    logic [DIGITS-1:0]   w_carry;
    logic [DIGITS-1:0]   w_nib_bad;
    logic                w_limit_ok;
    logic [c_w-1:0]      w_step;
    logic [c_w-1:0]      w_load;
    logic                w_term;

    // Bit i set when nibble i differs between the two packed values.
    function automatic logic [DIGITS-1:0] f_changed(input logic [c_w-1:0] a,
                                                    input logic [c_w-1:0] b);
        logic [DIGITS-1:0] v;
        v = '0;
        for (int i = 0; i < DIGITS; i++) begin
            v[i] = (a[4*i +: 4] != b[4*i +: 4]);
        end
        return v;
    endfunction

    // Incrementer: nibble-wise ripple, a 9 wraps to 0 and carries onward.
    assign w_carry[0] = 1'b1;
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_up
        logic [3:0] w_dig;
        assign w_dig = r_count[4*gi +: 4];
        assign w_up[4*gi +: 4] = w_carry[gi] ? ((w_dig == 4'd9) ? 4'd0 : w_dig + 4'd1)
                                             : w_dig;
        if (gi < DIGITS - 1) begin : g_cy
            assign w_carry[gi+1] = w_carry[gi] & (w_dig == 4'd9);
        end
    end

    // A start is only accepted for a nonzero limit made of legal BCD digits.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lim
        assign w_nib_bad[gi] = (bus.limit[4*gi +: 4] > 4'd9);
    end
    assign w_limit_ok = ~(|w_nib_bad) && (bus.limit != '0);

`ifdef BCD_DOWN_EN
    logic                r_dir;
    logic [c_w-1:0]      w_dn;
    logic [DIGITS-1:0]   w_borrow;

    // Decrementer: nibble-wise ripple, a 0 wraps to 9 and borrows onward.
    assign w_borrow[0] = 1'b1;
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dn
        logic [3:0] w_dig;
        assign w_dig = r_count[4*gi +: 4];
        assign w_dn[4*gi +: 4] = w_borrow[gi] ? ((w_dig == 4'd0) ? 4'd9 : w_dig - 4'd1)
                                              : w_dig;
        if (gi < DIGITS - 1) begin : g_bw
            assign w_borrow[gi+1] = w_borrow[gi] & (w_dig == 4'd0);
        end
    end

    assign w_step = r_dir ? w_dn : w_up;
    assign w_term = r_dir ? (w_dn == '0) : (w_up == r_limit);
    assign w_load = bus.dir ? bus.limit : '0;
`else
    assign w_step = w_up;
    assign w_term = (w_up == r_limit);
    assign w_load = '0;
`endif

    // Main FSM: command decode (clr > stop > start > tick) and all outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_limit    <= '0;
            r_digit_en <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
`ifdef BCD_DOWN_EN
            r_dir      <= 1'b0;
`endif
        end else begin
            r_digit_en <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            if (bus.clr) begin
                r_count    <= '0;
                r_digit_en <= f_changed(r_count, '0);
                r_state    <= ST_IDLE;
                r_busy     <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        if (bus.start) begin
                            if (!w_limit_ok) begin
                                r_err <= 1'b1;
                            end else begin
                                r_limit    <= bus.limit;
`ifdef BCD_DOWN_EN
                                r_dir      <= bus.dir;
`endif
                                r_count    <= w_load;
                                r_digit_en <= f_changed(r_count, w_load);
                                r_state    <= ST_RUN;
                                r_busy     <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        // A stop swallows any tick seen in the same cycle.
                        if (bus.stop) begin
                            r_state <= ST_HOLD;
                        end else if (bus.tick) begin
                            r_count    <= w_step;
                            r_digit_en <= f_changed(r_count, w_step);
                            if (w_term) begin
                                r_state <= ST_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    ST_HOLD: begin
                        // Resume keeps both count and the captured limit.
                        if (bus.start) begin
                            r_state <= ST_RUN;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.count    = r_count;
    assign bus.digit_en = r_digit_en;
    assign bus.state    = r_state;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_seq_ctrl
//  Description : Directed self-checking bench for bcd_seq_ctrl (DIGITS=2).
//                Down-count scenario is compiled only with BCD_DOWN_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    bcd_seq_if #(.DIGITS(2)) bus ();

    bcd_seq_ctrl #(.DIGITS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Advance one clock; sample and drive 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] bcd2(input int v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    function automatic logic [1:0] nib_diff(input logic [7:0] a, input logic [7:0] b);
        return {a[7:4] != b[7:4], a[3:0] != b[3:0]};
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_count"}, 32'(bus.count), 32'h00);
        chk({tag, "_state"}, 32'(bus.state), 32'h0);
        chk({tag, "_busy"},  32'(bus.busy),  32'h0);
        chk({tag, "_done"},  32'(bus.done),  32'h0);
        chk({tag, "_err"},   32'(bus.err),   32'h0);
        chk({tag, "_den"},   32'(bus.digit_en), 32'h0);
    endtask

    initial begin
        logic [7:0] prev;
        logic [7:0] expv;

        bus.start = 1'b0; bus.stop = 1'b0; bus.clr = 1'b0; bus.tick = 1'b0;
        bus.limit = 8'h00;
`ifdef BCD_DOWN_EN
        bus.dir = 1'b0;
`endif
        step(); step();
        rst = 1'b0;
        chk_reset_outputs("reset");

        // ---- Up count 00 -> 12 with tick held high ----
        bus.limit = 8'h12; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("up_load_state", 32'(bus.state), 32'h1);
        chk("up_load_busy",  32'(bus.busy),  32'h1);
        chk("up_load_count", 32'(bus.count), 32'h00);
        bus.tick = 1'b1;
        prev = 8'h00;
        for (int k = 1; k <= 12; k++) begin
            step();
            expv = bcd2(k);
            chk($sformatf("up_count_%0d", k), 32'(bus.count), 32'(expv));
            chk($sformatf("up_den_%0d", k), 32'(bus.digit_en), 32'(nib_diff(prev, expv)));
            chk($sformatf("up_done_%0d", k), 32'(bus.done), (k == 12) ? 32'h1 : 32'h0);
            prev = expv;
        end
        chk("up_end_state", 32'(bus.state), 32'h3);
        chk("up_end_busy",  32'(bus.busy),  32'h0);
        step();
        chk("done_hold_count", 32'(bus.count), 32'h12);
        chk("done_one_cycle",  32'(bus.done),  32'h0);
        chk("done_hold_state", 32'(bus.state), 32'h3);
        chk("done_hold_den",   32'(bus.digit_en), 32'h0);
        bus.tick = 1'b0;

        // ---- clr from DONE ----
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        chk("clr_done_count", 32'(bus.count), 32'h00);
        chk("clr_done_state", 32'(bus.state), 32'h0);
        chk("clr_done_den",   32'(bus.digit_en), 32'h3);

        // ---- rejected starts ----
        bus.limit = 8'h1A; bus.start = 1'b1;
        step();
        chk("bad_digit_err",   32'(bus.err),   32'h1);
        chk("bad_digit_state", 32'(bus.state), 32'h0);
        chk("bad_digit_count", 32'(bus.count), 32'h00);
        step();
        chk("bad_digit_err_repeat", 32'(bus.err), 32'h1);
        bus.limit = 8'h00;
        step();
        chk("zero_limit_err",   32'(bus.err),   32'h1);
        chk("zero_limit_state", 32'(bus.state), 32'h0);
        bus.start = 1'b0;
        step();
        chk("err_clears", 32'(bus.err), 32'h0);

        // ---- stop/tick collision, HOLD and resume ----
        bus.limit = 8'h09; bus.start = 1'b1;
        step();
        bus.start = 1'b0; bus.tick = 1'b1;
        for (int k = 0; k < 5; k++) step();
        chk("pre_stop_count", 32'(bus.count), 32'h05);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        chk("hold_state", 32'(bus.state), 32'h2);
        chk("hold_count", 32'(bus.count), 32'h05);
        chk("hold_busy",  32'(bus.busy),  32'h1);
        bus.start = 1'b1;
        step();
        chk("resume_state", 32'(bus.state), 32'h1);
        chk("resume_count", 32'(bus.count), 32'h05);
        step();
        chk("resume_step_count", 32'(bus.count), 32'h06);
        bus.start = 1'b0;
        step();
        chk("pre_clr_count", 32'(bus.count), 32'h07);

        // ---- clr beats start while running ----
        bus.clr = 1'b1; bus.start = 1'b1;
        step();
        bus.clr = 1'b0; bus.start = 1'b0; bus.tick = 1'b0;
        chk("clr_run_count", 32'(bus.count), 32'h00);
        chk("clr_run_state", 32'(bus.state), 32'h0);
        chk("clr_run_done",  32'(bus.done),  32'h0);
        chk("clr_run_den",   32'(bus.digit_en), 32'h1);
        chk("clr_run_busy",  32'(bus.busy),  32'h0);

`ifdef BCD_DOWN_EN
        // ---- down count 20 -> 00 ----
        bus.dir = 1'b1; bus.limit = 8'h20; bus.start = 1'b1;
        step();
        bus.start = 1'b0; bus.dir = 1'b0;
        chk("dn_load_count", 32'(bus.count), 32'h20);
        chk("dn_load_state", 32'(bus.state), 32'h1);
        bus.tick = 1'b1;
        prev = 8'h20;
        for (int k = 19; k >= 0; k--) begin
            step();
            expv = bcd2(k);
            chk($sformatf("dn_count_%0d", k), 32'(bus.count), 32'(expv));
            chk($sformatf("dn_den_%0d", k), 32'(bus.digit_en), 32'(nib_diff(prev, expv)));
            chk($sformatf("dn_done_%0d", k), 32'(bus.done), (k == 0) ? 32'h1 : 32'h0);
            prev = expv;
        end
        chk("dn_end_state", 32'(bus.state), 32'h3);
        bus.tick = 1'b0;
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
`endif

        // ---- reset mid-count at 33 ----
        bus.limit = 8'h45; bus.start = 1'b1;
        step();
        bus.start = 1'b0; bus.tick = 1'b1;
        for (int k = 0; k < 33; k++) step();
        chk("pre_rst_count", 32'(bus.count), 32'h33);
        rst = 1'b1;
        step();
        chk_reset_outputs("mid_rst");
        rst = 1'b0;
        step();
        chk("post_rst_count", 32'(bus.count), 32'h00);
        chk("post_rst_state", 32'(bus.state), 32'h0);
        bus.tick = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
